// File: rtl/skinny_mask_pkg.sv
// Shared constants and helpers for the masked Skinny-64 S-box layer.
// Widths derive from the masking order d and the lane count:
//   shares = d+1, state width = 4*lanes, randomness per AND = d(d+1).
// Also holds the plain S-box table and the share-major packing index.
package skinny_mask_pkg;

  localparam int LATENCY = 5;

  function automatic int n_shares(input int d);
    return d + 1;
  endfunction

  function automatic int sbox_w(input int nsbox);
    return 4 * nsbox;
  endfunction

  function automatic int rnd_per_and(input int d);
    return d * (d + 1);
  endfunction

  function automatic int fresh_w(input int d, input int nsbox);
    return 4 * nsbox * d * (d + 1);
  endfunction

  // Dense index of share pair (i,j), i<j, among n shares.
  function automatic int pair_idx(input int i, input int j, input int n);
    return i * n - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  // Bit offset of lane i's nibble within share s.
  function automatic int sh_idx(input int s, input int i, input int nsbox);
    return s * 4 * nsbox + 4 * i;
  endfunction

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h6;  4'h2: sbox = 4'h9;  4'h3: sbox = 4'h0;
      4'h4: sbox = 4'h1;  4'h5: sbox = 4'hA;  4'h6: sbox = 4'h2;  4'h7: sbox = 4'hB;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'h8;  4'hA: sbox = 4'h5;  4'hB: sbox = 4'hD;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'hE;  4'hE: sbox = 4'h7;  default: sbox = 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/skinny_sbox_layer_hpc1_if.sv
// Bus between the round datapath and the masked S-box layer.
//   master: drives en, in_valid, x_sh, fresh; observes out_valid, y_sh, inflight, idle
//   slave : the S-box layer itself
interface skinny_sbox_layer_hpc1_if import skinny_mask_pkg::*; #(
  parameter int SEC_ORDER = 1,
  parameter int NUM_SBOX  = 16
);
  localparam int SW = n_shares(SEC_ORDER) * sbox_w(NUM_SBOX);
  localparam int FW = fresh_w(SEC_ORDER, NUM_SBOX);

  logic          en;
  logic          in_valid;
  logic [SW-1:0] x_sh;
  logic [FW-1:0] fresh;
  logic          out_valid;
  logic [SW-1:0] y_sh;
  logic [2:0]    inflight;
  logic          idle;

  modport master (output en, in_valid, x_sh, fresh,
                  input  out_valid, y_sh, inflight, idle);
  modport slave  (input  en, in_valid, x_sh, fresh,
                  output out_valid, y_sh, inflight, idle);
endinterface

// File: rtl/skinny_sbox_lane_hpc1.sv
// One HPC1-masked Skinny-64 S-box, 5-stage pipeline, all regs gated by en_i.
// With input bits (a,b,c,d) = x[0..3] the S-box reduces to
//   y3 = a ^ (~c & ~d)     y2 = d ^ (~b & ~c)      (AND1 / AND3, depth 2)
//   y1 = c ^ (~y3 & ~b)    y0 = b ^ (~y2 & ~y3)    (AND2 / AND4, depth 4)
// followed by the output register (depth 5).
// Ports: clk, rst_n, en_i; x_i/y_o shares [share][nibble];
//        fresh_i 4 slices of d(d+1) bits: AND1, AND3, AND2, AND4.
module skinny_sbox_lane_hpc1 import skinny_mask_pkg::*; #(
  parameter int SEC_ORDER = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  en_i,
  input  logic [SEC_ORDER:0][3:0]               x_i,
  input  logic [4*SEC_ORDER*(SEC_ORDER+1)-1:0]  fresh_i,
  output logic [SEC_ORDER:0][3:0]               y_o
);
  localparam int N = n_shares(SEC_ORDER);
  localparam int R = rnd_per_and(SEC_ORDER);
  localparam int H = R / 2;
  // Masked NOT only flips share 0.
  localparam logic [N-1:0] S0 = N'(1);

  logic [3:0][N-1:0]      xt, x1_q, x2_q;
  logic [2:1][1:0][N-1:0] x34_q;  // {c, b} carried on to depth 4
  logic [2:1][1:0][N-1:0] yh_q;   // {y3, y2} carried on to depth 4
  logic [N-1:0]           y3, y2, y1, y0;
  logic [3:0][N-1:0]      ga, gb, gc;  // gadget slot order: AND1, AND3, AND2, AND4
  logic [N-1:0][3:0]      y_q;

  for (genvar s = 0; s < N; s++) begin : g_sh
    for (genvar k = 0; k < 4; k++) begin : g_bit
      assign xt[k][s] = x_i[s][k];
    end
  end

  assign ga[0] = xt[2] ^ S0;      assign gb[0] = xt[3] ^ S0;
  assign ga[1] = xt[1] ^ S0;      assign gb[1] = xt[2] ^ S0;
  assign y3    = x2_q[0] ^ gc[0];
  assign y2    = x2_q[3] ^ gc[1];
  assign ga[2] = y3 ^ S0;         assign gb[2] = x2_q[1] ^ S0;
  assign ga[3] = y2 ^ S0;         assign gb[3] = y3 ^ S0;
  assign y1    = x34_q[2][1] ^ gc[2];
  assign y0    = x34_q[2][0] ^ gc[3];

  // HPC1 AND: b is refreshed with one random per share pair and registered
  // alongside a; cross products get a second set of pair randoms before the
  // product register. Share-wise XOR of the product register is the output.
  for (genvar g = 0; g < 4; g++) begin : g_and
    logic [N-1:0]        a_q, b_q, b_ref, c;
    logic [N-1:0][N-1:0] t_q;

    always_comb begin
      b_ref = gb[g];
      for (int i = 0; i < N; i++)
        for (int j = i + 1; j < N; j++) begin
          b_ref[i] = b_ref[i] ^ fresh_i[g*R + pair_idx(i, j, N)];
          b_ref[j] = b_ref[j] ^ fresh_i[g*R + pair_idx(i, j, N)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q <= '0;
        b_q <= '0;
        t_q <= '0;
      end else if (en_i) begin
        a_q <= ga[g];
        b_q <= b_ref;
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            if (i == j) t_q[i][j] <= a_q[i] & b_q[j];
            else        t_q[i][j] <= (a_q[i] & b_q[j]) ^
                                     fresh_i[g*R + H + pair_idx(i < j ? i : j, i < j ? j : i, N)];
      end
    end

    always_comb begin
      c = '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          c[i] = c[i] ^ t_q[i][j];
    end
    assign gc[g] = c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1_q  <= '0;
      x2_q  <= '0;
      x34_q <= '0;
      yh_q  <= '0;
      y_q   <= '0;
    end else if (en_i) begin
      x1_q  <= xt;
      x2_q  <= x1_q;
      x34_q <= {x34_q[1], x2_q[2], x2_q[1]};
      yh_q  <= {yh_q[1], y3, y2};
      for (int s = 0; s < N; s++)
        y_q[s] <= {yh_q[2][1][s], yh_q[2][0][s], y1[s], y0[s]};
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/skinny_sbox_layer_hpc1.sv
// NUM_SBOX parallel HPC1-masked Skinny-64 S-boxes with valid pipeline and
// in-flight counter. All outputs come straight from registers.
// Ports: clk, rst_n (async, active low); bus (slave): en, in_valid, x_sh,
//        fresh in; out_valid, y_sh, inflight, idle out.
module skinny_sbox_layer_hpc1 import skinny_mask_pkg::*; #(
  parameter int SEC_ORDER = 1,
  parameter int NUM_SBOX  = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  skinny_sbox_layer_hpc1_if.slave  bus
);
  localparam int N  = n_shares(SEC_ORDER);
  localparam int RL = 4 * rnd_per_and(SEC_ORDER);

  logic [NUM_SBOX-1:0][N-1:0][3:0] lane_x, lane_y;
  logic [N*4*NUM_SBOX-1:0]         y_flat;
  logic [LATENCY:1]                vld_pipe;
  logic [2:0]                      inflight_q, inflight_d;
  logic                            idle_q, accept;

  for (genvar i = 0; i < NUM_SBOX; i++) begin : g_lane
    for (genvar s = 0; s < N; s++) begin : g_sh
      assign lane_x[i][s] = bus.x_sh[sh_idx(s, i, NUM_SBOX) +: 4];
      assign y_flat[sh_idx(s, i, NUM_SBOX) +: 4] = lane_y[i][s];
    end
    skinny_sbox_lane_hpc1 #(.SEC_ORDER(SEC_ORDER)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (bus.en),
      .x_i     (lane_x[i]),
      .fresh_i (bus.fresh[i*RL +: RL]),
      .y_o     (lane_y[i])
    );
  end

  assign accept = bus.en & bus.in_valid;

  // Accept and retire on the same edge cancel out.
  always_comb begin
    inflight_d = inflight_q;
    if (accept && !vld_pipe[LATENCY])      inflight_d = inflight_q + 3'd1;
    else if (!accept && vld_pipe[LATENCY]) inflight_d = inflight_q - 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe   <= '0;
      inflight_q <= '0;
      idle_q     <= 1'b1;
    end else if (bus.en) begin
      vld_pipe   <= {vld_pipe[LATENCY-1:1], accept};
      inflight_q <= inflight_d;
      idle_q     <= (inflight_d == 3'd0);
    end
  end

  assign bus.out_valid = vld_pipe[LATENCY];
  assign bus.y_sh      = y_flat;
  assign bus.inflight  = inflight_q;
  assign bus.idle      = idle_q;

endmodule

// File: tb/tb_skinny_sbox_layer_hpc1.sv
module tb_skinny_sbox_layer_hpc1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  skinny_sbox_layer_hpc1_if #(.SEC_ORDER(1), .NUM_SBOX(16)) bus ();
  skinny_sbox_layer_hpc1_if #(.SEC_ORDER(2), .NUM_SBOX(1))  bus2 ();
  skinny_sbox_layer_hpc1_if #(.SEC_ORDER(3), .NUM_SBOX(1))  bus3 ();

  skinny_sbox_layer_hpc1 #(.SEC_ORDER(1), .NUM_SBOX(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  skinny_sbox_layer_hpc1 #(.SEC_ORDER(2), .NUM_SBOX(1))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  skinny_sbox_layer_hpc1 #(.SEC_ORDER(3), .NUM_SBOX(1))  dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  // Reference S-box table, index = input nibble.
  logic [3:0] SB [16] = '{4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
                          4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF};

  typedef struct {
    logic [63:0] y;
    int          due;   // en-edge count after which the item is at the output
  } item_t;

  item_t q[$];
  int    en_cnt = 0;
  int    peak   = 0;
  int    n_chk  = 0;
  int    n_err  = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] sbox_ref(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = SB[x[4*i +: 4]];
    return r;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One clock cycle on the d=1 DUT: drive, advance the model, check outputs.
  task automatic step(input bit en, input bit iv, input logic [63:0] x, input bit zf);
    logic [63:0] r;
    item_t       it;
    bit          exp_v;
    @(negedge clk);
    r            = rnd64();
    bus.en       = en;
    bus.in_valid = iv;
    bus.x_sh     = {r, x ^ r};
    bus.fresh    = zf ? 128'd0 : {rnd64(), rnd64()};
    @(posedge clk);
    if (en) begin
      en_cnt++;
      if (iv) begin
        it.y   = sbox_ref(x);
        it.due = en_cnt + 4;
        q.push_back(it);
      end
    end
    #1;
    while (q.size() > 0 && q[0].due < en_cnt) void'(q.pop_front());
    exp_v = (q.size() > 0 && q[0].due == en_cnt);
    chk("out_valid", 128'(bus.out_valid), 128'(exp_v));
    chk("inflight", 128'(bus.inflight), 128'(q.size()));
    chk("idle", 128'(bus.idle), 128'(q.size() == 0));
    if (exp_v) chk("y", 128'(bus.y_sh[63:0] ^ bus.y_sh[127:64]), 128'(q[0].y));
    if (int'(bus.inflight) > peak) peak = int'(bus.inflight);
  endtask

  task automatic drain();
    repeat (6) step(1'b1, 1'b0, rnd64(), 1'b0);
  endtask

  initial begin
    logic [63:0] xk;
    logic [3:0]  r1, r2, r3;
    logic [63:0] t;

    bus.en = 0;  bus.in_valid = 0;  bus.x_sh = '0;  bus.fresh = '0;
    bus2.en = 0; bus2.in_valid = 0; bus2.x_sh = '0; bus2.fresh = '0;
    bus3.en = 0; bus3.in_valid = 0; bus3.x_sh = '0; bus3.fresh = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_inflight", 128'(bus.inflight), 128'(0));
    chk("rst_idle", 128'(bus.idle), 128'(1));
    chk("rst_y_sh", bus.y_sh, 128'(0));
    @(negedge clk) rst_n = 1'b1;

    // Known answer: S applied nibble-wise to 0123456789ABCDEF
    xk = 64'h0123456789ABCDEF;
    step(1'b1, 1'b1, xk, 1'b0);
    repeat (4) step(1'b1, 1'b0, rnd64(), 1'b0);
    chk("kat", 128'(bus.y_sh[63:0] ^ bus.y_sh[127:64]), 128'(64'hC6901A2B385D4E7F));
    drain();

    // 1000 fresh maskings of the same state, back to back
    for (int i = 0; i < 1000; i++) step(1'b1, 1'b1, xk, 1'b0);
    drain();

    // Back-to-back constant states
    peak = 0;
    step(1'b1, 1'b1, 64'h0, 1'b0);
    step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    step(1'b1, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
    repeat (2) step(1'b1, 1'b0, rnd64(), 1'b0);
    chk("b2b_0", 128'(bus.y_sh[63:0] ^ bus.y_sh[127:64]), 128'(64'hCCCC_CCCC_CCCC_CCCC));
    step(1'b1, 1'b0, rnd64(), 1'b0);
    chk("b2b_f", 128'(bus.y_sh[63:0] ^ bus.y_sh[127:64]), 128'(64'hFFFF_FFFF_FFFF_FFFF));
    step(1'b1, 1'b0, rnd64(), 1'b0);
    chk("b2b_a", 128'(bus.y_sh[63:0] ^ bus.y_sh[127:64]), 128'(64'h5555_5555_5555_5555));
    chk("peak", 128'(peak), 128'(3));
    drain();

    // Stall with two items in flight; in_valid during the stall is dropped
    step(1'b1, 1'b1, rnd64(), 1'b0);
    step(1'b1, 1'b1, rnd64(), 1'b0);
    step(1'b1, 1'b0, rnd64(), 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, rnd64(), 1'b0);
      chk("stall_inflight", 128'(bus.inflight), 128'(2));
    end
    repeat (8) step(1'b1, 1'b0, rnd64(), 1'b0);

    // Asynchronous reset with an item three stages deep
    step(1'b1, 1'b1, rnd64(), 1'b0);
    repeat (2) step(1'b1, 1'b0, rnd64(), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("mid_rst_inflight", 128'(bus.inflight), 128'(0));
    chk("mid_rst_idle", 128'(bus.idle), 128'(1));
    chk("mid_rst_y_sh", bus.y_sh, 128'(0));
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    step(1'b1, 1'b1, xk, 1'b0);
    repeat (5) step(1'b1, 1'b0, rnd64(), 1'b0);

    // Random traffic with random stalls
    for (int i = 0; i < 300; i++)
      step($urandom_range(3) != 0, $urandom_range(1) != 0, rnd64(), 1'b0);
    drain();

    // Fresh randomness tied to zero
    for (int i = 0; i < 40; i++)
      step(1'b1, $urandom_range(1) != 0, rnd64(), 1'b1);
    drain();
    bus.en = 1'b0;

    // d=2 and d=3, single lane, every nibble
    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      r1 = 4'($urandom_range(15)); r2 = 4'($urandom_range(15)); r3 = 4'($urandom_range(15));
      bus2.en = 1'b1; bus2.in_valid = 1'b1; bus2.x_sh = {r2, r1, 4'(v) ^ r1 ^ r2};
      bus3.en = 1'b1; bus3.in_valid = 1'b1; bus3.x_sh = {r3, r2, r1, 4'(v) ^ r1 ^ r2 ^ r3};
      t = rnd64(); bus2.fresh = t[23:0]; bus3.fresh = t[63:16];
      @(negedge clk);
      bus2.in_valid = 1'b0; bus3.in_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
        t = rnd64(); bus2.fresh = t[23:0]; bus3.fresh = t[63:16];
        bus2.x_sh = t[35:24]; bus3.x_sh = t[63:48];
        @(negedge clk);
      end
      chk("d2_valid", 128'(bus2.out_valid), 128'(1));
      chk("d2_y", 128'(bus2.y_sh[3:0] ^ bus2.y_sh[7:4] ^ bus2.y_sh[11:8]), 128'(SB[v]));
      chk("d3_valid", 128'(bus3.out_valid), 128'(1));
      chk("d3_y", 128'(bus3.y_sh[3:0] ^ bus3.y_sh[7:4] ^ bus3.y_sh[11:8] ^ bus3.y_sh[15:12]),
          128'(SB[v]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
